// File: rtl/raycast_pkg.sv
// raycast_pkg
//   Shared constants and helpers for the ray-cast column writer.
//   - Screen geometry and pixel width.
//   - Default ceiling/floor colours.
//   - Writer state enum.
//   - RGB565 halving helper used for side shading.
package raycast_pkg;

  localparam int PIXEL_WIDTH   = 16;
  localparam int SCREEN_WIDTH  = 320;
  localparam int SCREEN_HEIGHT = 180;

  localparam logic [15:0] CEIL_COLOR_DEFAULT  = 16'h4208;
  localparam logic [15:0] FLOOR_COLOR_DEFAULT = 16'h8410;

  typedef enum logic {
    IDLE,
    DRAW
  } state_t;

  // Halve each RGB565 channel independently so no bit bleeds from one
  // channel into the next (red lsb must not land in green msb, etc).
  function automatic logic [15:0] rgb565_halve(input logic [15:0] color);
    return {1'b0, color[15:12], 1'b0, color[10:6], 1'b0, color[4:1]};
  endfunction

endpackage

// File: rtl/column_span_calc.sv
// column_span_calc
//   Combinational wall-span placement for one column.
//   Ports:
//     i_wall_height  - requested wall height in rows
//     o_top          - first wall row
//     o_bottom       - first floor row (exclusive end of the wall)
//   The height is clamped to the screen, then centred; the odd spare row
//   of an uneven gap ends up below the wall because the shift floors.
module column_span_calc
  import raycast_pkg::*;
#(
  parameter int SCREEN_HEIGHT = raycast_pkg::SCREEN_HEIGHT
) (
  input  logic [7:0] i_wall_height,
  output logic [7:0] o_top,
  output logic [7:0] o_bottom
);

  localparam logic [7:0] HEIGHT = 8'(SCREEN_HEIGHT);

  logic [7:0] w_height;
  logic [7:0] w_gap;

  assign w_height = (i_wall_height > HEIGHT) ? HEIGHT : i_wall_height;
  assign w_gap    = HEIGHT - w_height;
  assign o_top    = w_gap >> 1;
  assign o_bottom = o_top + w_height;

endmodule

// File: rtl/ray_column_writer.sv
// ray_column_writer
//   Expands one ray-cast column descriptor into SCREEN_HEIGHT sequential
//   frame-buffer writes (ceiling, wall, floor), one pixel per clock.
//   Ports:
//     pixel_clk_in        - clock, rising edge
//     rst_in              - asynchronous active-high reset
//     column_valid_in     - column descriptor valid
//     column_ready_out    - column can be accepted this cycle
//     column_x_in         - screen column index
//     wall_height_in      - wall span height in rows
//     wall_color_in       - RGB565 wall colour
//     wall_side_in        - 1 = y-side hit, wall is shaded
//     ray_valid_out       - address/pixel valid (registered)
//     ray_address_out     - flat address x + SCREEN_WIDTH*y (registered)
//     ray_pixel_out       - RGB565 pixel (registered)
//     ray_last_pixel_out  - pulse on the bottom-right pixel of the frame
module ray_column_writer #(
  parameter int PIXEL_WIDTH   = raycast_pkg::PIXEL_WIDTH,
  parameter int SCREEN_WIDTH  = raycast_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = raycast_pkg::SCREEN_HEIGHT,
  parameter logic [PIXEL_WIDTH-1:0] CEIL_COLOR  = raycast_pkg::CEIL_COLOR_DEFAULT,
  parameter logic [PIXEL_WIDTH-1:0] FLOOR_COLOR = raycast_pkg::FLOOR_COLOR_DEFAULT
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_in,
  input  logic                   column_valid_in,
  output logic                   column_ready_out,
  input  logic [8:0]             column_x_in,
  input  logic [7:0]             wall_height_in,
  input  logic [15:0]            wall_color_in,
  input  logic                   wall_side_in,
  output logic                   ray_valid_out,
  output logic [15:0]            ray_address_out,
  output logic [PIXEL_WIDTH-1:0] ray_pixel_out,
  output logic                   ray_last_pixel_out
);

  import raycast_pkg::*;

  localparam logic [7:0]  LAST_ROW     = 8'(SCREEN_HEIGHT - 1);
  localparam logic [8:0]  COLUMN_LIMIT = 9'(SCREEN_WIDTH);
  localparam logic [8:0]  LAST_COLUMN  = 9'(SCREEN_WIDTH - 1);
  localparam logic [15:0] ROW_STRIDE   = 16'(SCREEN_WIDTH);

  state_t r_state;
  state_t w_next_state;

  logic                   w_ready;
  logic                   w_load;
  logic                   w_last_row;
  logic [7:0]             w_span_top;
  logic [7:0]             w_span_bottom;
  logic [PIXEL_WIDTH-1:0] w_pixel;

  logic [7:0]             r_y;
  logic [15:0]            r_addr;
  logic [8:0]             r_x;
  logic [PIXEL_WIDTH-1:0] r_wall_color;
  logic [7:0]             r_top;
  logic [7:0]             r_bottom;

  logic                   r_valid;
  logic [15:0]            r_address;
  logic [PIXEL_WIDTH-1:0] r_pixel;
  logic                   r_last;

  column_span_calc #(
    .SCREEN_HEIGHT(SCREEN_HEIGHT)
  ) u_span (
    .i_wall_height(wall_height_in),
    .o_top        (w_span_top),
    .o_bottom     (w_span_bottom)
  );

  assign w_last_row = (r_state == DRAW) && (r_y == LAST_ROW);

  // State register.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake. Ready is also raised on the final row so a
  // new column can be taken on the same edge that emits row 179, which is
  // what keeps back-to-back columns bubble-free. An out-of-range column is
  // still handshaken but never loaded, so the writer falls back to IDLE.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_load       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ready = 1'b1;
      end
      DRAW: begin
        if (r_y == LAST_ROW) begin
          w_ready      = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
    if (w_ready && column_valid_in && (column_x_in < COLUMN_LIMIT)) begin
      w_load       = 1'b1;
      w_next_state = DRAW;
    end
  end

  // Row colour selection against the span captured for this column.
  always_comb begin
    w_pixel = FLOOR_COLOR;
    if (r_y < r_top) begin
      w_pixel = CEIL_COLOR;
    end else if (r_y < r_bottom) begin
      w_pixel = r_wall_color;
    end
  end

  // Column datapath and registered outputs. The address is accumulated one
  // row stride at a time instead of multiplying x + width*y. A load on the
  // final-row edge overrides the row/address advance so the new column
  // starts cleanly at y=0 while the old column's last row is still emitted.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_y          <= '0;
      r_addr       <= '0;
      r_x          <= '0;
      r_wall_color <= '0;
      r_top        <= '0;
      r_bottom     <= '0;
      r_valid      <= 1'b0;
      r_address    <= '0;
      r_pixel      <= '0;
      r_last       <= 1'b0;
    end else begin
      if (r_state == DRAW) begin
        r_valid   <= 1'b1;
        r_address <= r_addr;
        r_pixel   <= w_pixel;
        r_last    <= w_last_row && (r_x == LAST_COLUMN);
        if (w_last_row) begin
          r_y <= '0;
        end else begin
          r_y <= r_y + 8'd1;
        end
        r_addr <= r_addr + ROW_STRIDE;
      end else begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end

      if (w_load) begin
        r_x          <= column_x_in;
        r_wall_color <= wall_side_in ? rgb565_halve(wall_color_in) : wall_color_in;
        r_top        <= w_span_top;
        r_bottom     <= w_span_bottom;
        r_y          <= '0;
        r_addr       <= {7'd0, column_x_in};
      end
    end
  end

  assign column_ready_out   = w_ready;
  assign ray_valid_out      = r_valid;
  assign ray_address_out    = r_address;
  assign ray_pixel_out      = r_pixel;
  assign ray_last_pixel_out = r_last;

endmodule

// File: tb/tb_ray_column_writer.sv
// tb_ray_column_writer
//   Directed self-checking bench for ray_column_writer: reset values,
//   single columns with hand-computed spans, out-of-range columns, an
//   asynchronous reset mid-column and a full back-to-back frame stream.
module tb_ray_column_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        columnValid = 1'b0;
  logic [8:0]  columnX = '0;
  logic [7:0]  wallHeight = '0;
  logic [15:0] wallColor = '0;
  logic        wallSide = 1'b0;

  logic        columnReady;
  logic        rayValid;
  logic [15:0] rayAddress;
  logic [15:0] rayPixel;
  logic        rayLast;

  int errors = 0;
  int checks = 0;

  ray_column_writer dut (
    .pixel_clk_in      (clk),
    .rst_in            (rst),
    .column_valid_in   (columnValid),
    .column_ready_out  (columnReady),
    .column_x_in       (columnX),
    .wall_height_in    (wallHeight),
    .wall_color_in     (wallColor),
    .wall_side_in      (wallSide),
    .ray_valid_out     (rayValid),
    .ray_address_out   (rayAddress),
    .ray_pixel_out     (rayPixel),
    .ray_last_pixel_out(rayLast)
  );

  // 100 MHz pixel clock.
  always #5 clk = ~clk;

  // Single comparison point; prints are capped so a broken design cannot
  // flood the log, but every mismatch is still counted.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      if (errors <= 25)
        $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present one column and hold it for exactly one accepting edge.
  task automatic applyStimulus(input int x, input int h, input logic [15:0] color,
                               input logic side);
    @(negedge clk);
    columnX     = 9'(x);
    wallHeight  = 8'(h);
    wallColor   = color;
    wallSide    = side;
    columnValid = 1'b1;
    checkOutput("accept_ready", 32'(columnReady), 32'd1);
    @(posedge clk);
    #1;
    columnValid = 1'b0;
  endtask

  // One column with hand-computed span and wall colour, checked row by row.
  task automatic runColumn(input string name, input int x, input int h,
                           input logic [15:0] color, input logic side,
                           input int expTop, input int expBottom,
                           input logic [15:0] expWall);
    logic [15:0] expPix;
    applyStimulus(x, h, color, side);
    for (int r = 0; r < 180; r++) begin
      @(posedge clk);
      #1;
      if (r < expTop)         expPix = 16'h4208;
      else if (r < expBottom) expPix = expWall;
      else                    expPix = 16'h8410;
      checkOutput($sformatf("%s_r%0d_valid", name, r), 32'(rayValid), 32'd1);
      checkOutput($sformatf("%s_r%0d_addr", name, r), 32'(rayAddress), 32'(x + 320 * r));
      checkOutput($sformatf("%s_r%0d_pixel", name, r), 32'(rayPixel), 32'(expPix));
      checkOutput($sformatf("%s_r%0d_last", name, r), 32'(rayLast),
                  32'((x == 319) && (r == 179)));
    end
    @(posedge clk);
    #1;
    checkOutput({name, "_after_valid"}, 32'(rayValid), 32'd0);
    checkOutput({name, "_after_last"}, 32'(rayLast), 32'd0);
    checkOutput({name, "_after_ready"}, 32'(columnReady), 32'd1);
  endtask

  function automatic logic [15:0] streamColor(input int col);
    return 16'((col * 613) ^ 32'h5A3C);
  endfunction

  initial begin
    // Reset values while reset is held.
    #12;
    checkOutput("rst_valid", 32'(rayValid), 32'd0);
    checkOutput("rst_addr", 32'(rayAddress), 32'd0);
    checkOutput("rst_pixel", 32'(rayPixel), 32'd0);
    checkOutput("rst_last", 32'(rayLast), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_release_ready", 32'(columnReady), 32'd1);

    $display("[TB] single columns");
    runColumn("mid", 5, 100, 16'hF800, 1'b0, 40, 140, 16'hF800);
    runColumn("clamp", 319, 255, 16'hFFFF, 1'b1, 0, 180, 16'h7BEF);
    runColumn("zero", 100, 0, 16'h1234, 1'b0, 90, 90, 16'h1234);
    runColumn("odd", 200, 99, 16'hF800, 1'b1, 40, 139, 16'h7800);
    runColumn("full", 0, 180, 16'h001F, 1'b0, 0, 180, 16'h001F);
    runColumn("over", 318, 181, 16'h07E0, 1'b1, 0, 180, 16'h03E0);

    $display("[TB] out-of-range column");
    applyStimulus(320, 50, 16'hFFFF, 1'b0);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("oor_valid_%0d", c), 32'(rayValid), 32'd0);
      checkOutput($sformatf("oor_ready_%0d", c), 32'(columnReady), 32'd1);
      @(posedge clk);
      #1;
    end

    $display("[TB] reset mid-column");
    applyStimulus(319, 60, 16'h07E0, 1'b0);
    repeat (51) @(posedge clk);
    #1;
    checkOutput("midrst_row50_addr", 32'(rayAddress), 32'(319 + 320 * 50));
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 32'(rayValid), 32'd0);
    checkOutput("midrst_addr", 32'(rayAddress), 32'd0);
    checkOutput("midrst_pixel", 32'(rayPixel), 32'd0);
    checkOutput("midrst_last", 32'(rayLast), 32'd0);
    checkOutput("midrst_ready", 32'(columnReady), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("midrst_quiet_valid_%0d", c), 32'(rayValid), 32'd0);
      checkOutput($sformatf("midrst_quiet_last_%0d", c), 32'(rayLast), 32'd0);
    end
    runColumn("postrst", 12, 40, 16'hABCD, 1'b0, 70, 110, 16'hABCD);

    $display("[TB] back-to-back frame stream");
    fork
      begin : driver
        columnValid = 1'b1;
        for (int c = 0; c < 320; c++) begin
          int guard;
          guard       = 0;
          columnX     = 9'(c);
          wallHeight  = 8'(c);
          wallColor   = streamColor(c);
          wallSide    = c[0];
          while (!columnReady && guard < 400) begin
            @(negedge clk);
            guard++;
          end
          @(posedge clk);
          #1;
        end
        columnValid = 1'b0;
      end
      begin : monitor
        int waitCycles;
        int col;
        int row;
        int hc;
        int top;
        int bottom;
        logic [15:0] wall;
        logic [15:0] expPix;
        waitCycles = 0;
        @(posedge clk);
        #1;
        while (!rayValid && waitCycles < 400) begin
          @(posedge clk);
          #1;
          waitCycles++;
        end
        checkOutput("stream_start", 32'(rayValid), 32'd1);
        for (int k = 0; k < 57600; k++) begin
          if (k > 0) begin
            @(posedge clk);
            #1;
          end
          col    = k / 180;
          row    = k % 180;
          hc     = (col % 256 > 180) ? 180 : col % 256;
          top    = (180 - hc) / 2;
          bottom = top + hc;
          wall   = streamColor(col);
          if (col % 2 == 1) wall = (wall >> 1) & 16'h7BEF;
          if (row < top)         expPix = 16'h4208;
          else if (row < bottom) expPix = wall;
          else                   expPix = 16'h8410;
          checkOutput($sformatf("stream_k%0d_valid", k), 32'(rayValid), 32'd1);
          checkOutput($sformatf("stream_k%0d_addr", k), 32'(rayAddress),
                      32'(col + 320 * row));
          checkOutput($sformatf("stream_k%0d_pixel", k), 32'(rayPixel), 32'(expPix));
          checkOutput($sformatf("stream_k%0d_last", k), 32'(rayLast),
                      32'(k == 57599));
          checkOutput($sformatf("stream_k%0d_ready", k), 32'(columnReady),
                      32'((row == 178) || (k == 57599)));
        end
        @(posedge clk);
        #1;
        checkOutput("stream_end_valid", 32'(rayValid), 32'd0);
        checkOutput("stream_end_last", 32'(rayLast), 32'd0);
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
